// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: bundles the adder, decode-side redirect and instruction-memory
// signals of the fetch stage; master is the fetch unit, slave is its environment.
interface pc_fetch_unit_if;
  logic [31:0] add_pc;
  logic [31:0] add_num;
  logic [31:0] add_result;

  logic        stall;
  logic        redirect;
  logic [1:0]  npc_sel;
  logic [15:0] br_offset;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;

  modport master (
    output add_pc, add_num, imem_req, imem_addr, instr_out, instr_pc, instr_valid,
    input  add_result, stall, redirect, npc_sel, br_offset, j_index, jr_target,
           exc_req, eret_req, epc, imem_ready, imem_rdata
  );

  modport slave (
    input  add_pc, add_num, imem_req, imem_addr, instr_out, instr_pc, instr_valid,
    output add_result, stall, redirect, npc_sel, br_offset, j_index, jr_target,
           exc_req, eret_req, epc, imem_ready, imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus single-outstanding instruction fetch.
// Holds at most one word for decode and discards responses made stale by redirects.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input logic             clk,
  input logic             reset,
  pc_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addrHold_q, addrHold_d;
  logic [31:0] instrOut_q, instrOut_d;
  logic [31:0] instrPc_q, instrPc_d;
  logic        instrValid_q, instrValid_d;

  logic        canAccept;
  logic        imemReq;
  logic        redirValid;
  logic        redirTaken;
  logic        capture;
  logic [31:0] instrPcPlus4;
  logic [31:0] brOffsetExt;
  logic [31:0] redirTarget;

  // Exception beats eret, which beats any decode redirect; npc_sel=00 is no redirect.
  always_comb begin
    instrPcPlus4 = instrPc_q + 32'd4;
    brOffsetExt  = {{14{bus.br_offset[15]}}, bus.br_offset, 2'b00};
    redirValid   = bus.exc_req | bus.eret_req | (bus.redirect & (bus.npc_sel != 2'b00));
    if (bus.exc_req) begin
      redirTarget = EXC_VECTOR;
    end else if (bus.eret_req) begin
      redirTarget = bus.epc;
    end else begin
      unique case (bus.npc_sel)
        2'b10:   redirTarget = {instrPcPlus4[31:28], bus.j_index, 2'b00};
        2'b11:   redirTarget = {bus.jr_target[31:2], 2'b00};
        default: redirTarget = instrPcPlus4 + brOffsetExt;
      endcase
    end
  end

  assign redirTaken = redirValid & (state_q != IDLE);
  assign canAccept  = !instrValid_q | !bus.stall;
  assign imemReq    = ((state_q == FETCH) & canAccept) | (state_q == WAIT) | (state_q == DROP);

  assign bus.imem_req    = imemReq;
  assign bus.imem_addr   = ((state_q == WAIT) || (state_q == DROP)) ? addrHold_q : pc_q;
  assign bus.add_pc      = pc_q;
  assign bus.add_num     = 32'd4;
  assign bus.instr_out   = instrOut_q;
  assign bus.instr_pc    = instrPc_q;
  assign bus.instr_valid = instrValid_q;

  // In WAIT the PC still equals the held address, so capture can use pc_q/add_result
  // uniformly; DROP only ever waits out the stale response.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addrHold_d   = addrHold_q;
    instrOut_d   = instrOut_q;
    instrPc_d    = instrPc_q;
    instrValid_d = instrValid_q;
    capture      = 1'b0;

    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imemReq && !bus.imem_ready) begin
          addrHold_d = pc_q;
          state_d    = redirTaken ? DROP : WAIT;
        end else if (imemReq && !redirTaken) begin
          capture = 1'b1;
        end
      end
      WAIT: begin
        if (bus.imem_ready) begin
          state_d = FETCH;
          capture = !redirTaken;
        end else if (redirTaken) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.imem_ready) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirTaken) begin
      pc_d         = redirTarget;
      instrValid_d = 1'b0;
    end else if (capture) begin
      instrOut_d   = bus.imem_rdata;
      instrPc_d    = pc_q;
      instrValid_d = 1'b1;
      pc_d         = bus.add_result;
    end else if (instrValid_q && !bus.stall) begin
      instrValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      addrHold_q   <= 32'd0;
      instrOut_q   <= 32'd0;
      instrPc_q    <= 32'd0;
      instrValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addrHold_q   <= addrHold_d;
      instrOut_q   <= instrOut_d;
      instrPc_q    <= instrPc_d;
      instrValid_q <= instrValid_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level model of the fetched instruction stream.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  typedef struct {
    logic        stall;
    logic        ready;
    logic        redirect;
    logic [1:0]  npcSel;
    logic [15:0] brOffset;
    logic [25:0] jIndex;
    logic [31:0] jrTarget;
    logic [31:0] epc;
    logic        exc;
    logic        eret;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expInstrPc;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checkCount = 0;
  int   passCount = 0;

  pc_fetch_unit_if bus();

  pc_fetch_unit #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_1E97;
  endfunction

  assign bus.add_result = bus.add_pc + bus.add_num;
  assign bus.imem_rdata = memWord(bus.imem_addr);

  // Kind codes keep the directed table compact: each names one redirect scenario.
  function automatic vec_t mk(input logic s, input logic r, input int kind,
                              input logic eReq, input logic [31:0] eAddr,
                              input logic eValid, input logic [31:0] eIpc);
    vec_t v;
    v = '{default: '0};
    v.stall = s;
    v.ready = r;
    case (kind)
      1: begin v.redirect = 1'b1; v.npcSel = 2'b01; v.brOffset = 16'hFFFF; end
      2: v.exc = 1'b1;
      3: begin v.redirect = 1'b1; v.npcSel = 2'b00; v.brOffset = 16'h0040; end
      4: begin v.redirect = 1'b1; v.npcSel = 2'b10; v.jIndex = 26'h000_0C00; end
      5: begin
        v.eret = 1'b1; v.epc = 32'h0000_5000;
        v.redirect = 1'b1; v.npcSel = 2'b11; v.jrTarget = 32'h0000_6003;
      end
      6: begin v.redirect = 1'b1; v.npcSel = 2'b11; v.jrTarget = 32'h0000_6003; end
      7: begin v.exc = 1'b1; v.redirect = 1'b1; v.npcSel = 2'b01; v.brOffset = 16'h0010; end
      8: begin v.redirect = 1'b1; v.npcSel = 2'b11; v.jrTarget = 32'hFFFF_FFFC; end
      default: ;
    endcase
    v.expReq     = eReq;
    v.expAddr    = eAddr;
    v.expValid   = eValid;
    v.expInstrPc = eIpc;
    return v;
  endfunction

  function automatic logic refRedir(input vec_t v);
    return v.exc || v.eret || (v.redirect && v.npcSel != 2'b00);
  endfunction

  function automatic logic [31:0] refTarget(input vec_t v, input logic [31:0] ipc);
    logic signed [31:0] off;
    logic [31:0] nextSeq;
    off = $signed(v.brOffset);
    nextSeq = ipc + 32'd4;
    if (v.exc) return EXC_VECTOR;
    if (v.eret) return v.epc;
    if (v.npcSel == 2'b01) return nextSeq + 32'(off * 4);
    if (v.npcSel == 2'b10) return {nextSeq[31:28], v.jIndex, 2'b00};
    return v.jrTarget - (v.jrTarget % 32'd4);
  endfunction

  task automatic checkWord(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
  endtask

  task automatic driveInputs(input vec_t v);
    bus.stall      = v.stall;
    bus.imem_ready = v.ready;
    bus.redirect   = v.redirect;
    bus.npc_sel    = v.npcSel;
    bus.br_offset  = v.brOffset;
    bus.j_index    = v.jIndex;
    bus.jr_target  = v.jrTarget;
    bus.epc        = v.epc;
    bus.exc_req    = v.exc;
    bus.eret_req   = v.eret;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    driveInputs(v);
    #1;
  endtask

  // Release lands mid high phase so the following negedge still sees IDLE.
  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    driveInputs(mk(1'b0, 1'b0, 0, 1'b0, 32'd0, 1'b0, 32'd0));
    #1;
    checkBit("rst_imem_req", bus.imem_req, 1'b0);
    checkBit("rst_instr_valid", bus.instr_valid, 1'b0);
    checkWord("rst_instr_out", bus.instr_out, 32'd0);
    checkWord("rst_instr_pc", bus.instr_pc, 32'd0);
    checkWord("rst_add_pc", bus.add_pc, RESET_PC);
    checkWord("rst_add_num", bus.add_num, 32'd4);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    logic [31:0] expNext;
    logic [31:0] modelInstrPc;
    logic [31:0] heldAddr;
    logic [31:0] tgt;
    logic        holdPending;
    logic        preReq;
    logic        preValid;
    logic [31:0] preAddr;
    logic        redir;
    int          captures;
    int          r;

    driveInputs(mk(1'b0, 1'b0, 0, 1'b0, 32'd0, 1'b0, 32'd0));
    doReset();

    vecs.push_back(mk(0, 1, 0, 0, 32'h0,    0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h3000, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h3004, 1, 32'h3000));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,    1, 32'h3004));
    vecs.push_back(mk(0, 0, 0, 1, 32'h3008, 1, 32'h3004));
    vecs.push_back(mk(0, 0, 0, 1, 32'h3008, 0, 32'h3004));
    vecs.push_back(mk(0, 1, 0, 1, 32'h3008, 0, 32'h3004));
    vecs.push_back(mk(0, 0, 1, 1, 32'h300C, 1, 32'h3008));
    vecs.push_back(mk(0, 0, 0, 1, 32'h300C, 0, 32'h3008));
    vecs.push_back(mk(0, 1, 0, 1, 32'h300C, 0, 32'h3008));
    vecs.push_back(mk(0, 1, 0, 1, 32'h3008, 0, 32'h3008));
    vecs.push_back(mk(0, 1, 2, 1, 32'h300C, 1, 32'h3008));
    vecs.push_back(mk(0, 1, 0, 1, 32'h4180, 0, 32'h3008));
    vecs.push_back(mk(0, 1, 3, 1, 32'h4184, 1, 32'h4180));
    vecs.push_back(mk(0, 1, 4, 1, 32'h4188, 1, 32'h4184));
    vecs.push_back(mk(0, 1, 5, 1, 32'h3000, 0, 32'h4184));
    vecs.push_back(mk(0, 1, 6, 1, 32'h5000, 0, 32'h4184));
    vecs.push_back(mk(0, 1, 0, 1, 32'h6000, 0, 32'h4184));
    vecs.push_back(mk(0, 0, 0, 1, 32'h6004, 1, 32'h6000));
    vecs.push_back(mk(0, 0, 7, 1, 32'h6004, 0, 32'h6000));
    vecs.push_back(mk(0, 1, 0, 1, 32'h6004, 0, 32'h6000));
    vecs.push_back(mk(0, 1, 0, 1, 32'h4180, 0, 32'h6000));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,    1, 32'h4180));
    vecs.push_back(mk(0, 1, 0, 1, 32'h4184, 1, 32'h4180));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkBit($sformatf("vec%0d_req", i), bus.imem_req, vecs[i].expReq);
      if (vecs[i].expReq) checkWord($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].expAddr);
      checkBit($sformatf("vec%0d_valid", i), bus.instr_valid, vecs[i].expValid);
      checkWord($sformatf("vec%0d_ipc", i), bus.instr_pc, vecs[i].expInstrPc);
      if (vecs[i].expValid)
        checkWord($sformatf("vec%0d_instr", i), bus.instr_out, memWord(vecs[i].expInstrPc));
    end

    // Two-cycle memory latency on the first fetch.
    doReset();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0));
    checkBit("lat_req_c1", bus.imem_req, 1'b1);
    checkWord("lat_addr_c1", bus.imem_addr, 32'h3000);
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0));
    checkWord("lat_addr_c2", bus.imem_addr, 32'h3000);
    checkBit("lat_valid_c2", bus.instr_valid, 1'b0);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0));
    checkWord("lat_pc_after", bus.add_pc, 32'h3004);
    checkBit("lat_valid_after", bus.instr_valid, 1'b1);
    checkWord("lat_ipc_after", bus.instr_pc, 32'h3000);
    checkWord("lat_instr_after", bus.instr_out, memWord(32'h3000));
    checkWord("lat_next_addr", bus.imem_addr, 32'h3004);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0));
    checkBit("lat_single_capture", bus.instr_valid, 1'b0);
    checkWord("lat_ipc_kept", bus.instr_pc, 32'h3000);

    // PC wrap at the top of the address space, then reset abandoning a WAIT.
    applyStimulus(mk(0, 0, 8, 0, 0, 0, 0));
    checkWord("wrap_wait_addr", bus.imem_addr, 32'h3004);
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0));
    checkWord("wrap_drop_addr", bus.imem_addr, 32'h3004);
    checkWord("wrap_pc_redirected", bus.add_pc, 32'hFFFF_FFFC);
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0));
    checkWord("wrap_fetch_top", bus.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0));
    checkWord("wrap_fetch_zero", bus.imem_addr, 32'h0000_0000);
    checkWord("wrap_ipc", bus.instr_pc, 32'hFFFF_FFFC);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0));
    checkBit("wrap_wait_req", bus.imem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    checkBit("midwait_rst_req", bus.imem_req, 1'b0);
    checkWord("midwait_rst_pc", bus.add_pc, RESET_PC);
    checkBit("midwait_rst_valid", bus.instr_valid, 1'b0);
    bus.imem_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0));
    checkBit("postrst_idle_req", bus.imem_req, 1'b0);
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0));
    checkWord("postrst_addr", bus.imem_addr, RESET_PC);
    checkBit("postrst_valid", bus.instr_valid, 1'b0);

    // Randomized run: the model tracks only the expected stream of delivered addresses.
    doReset();
    expNext      = RESET_PC;
    modelInstrPc = 32'd0;
    holdPending  = 1'b0;
    heldAddr     = 32'd0;
    captures     = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v = '{default: '0};
      v.stall = ($urandom_range(0, 3) == 0);
      v.ready = ($urandom_range(0, 2) != 0);
      r = (cyc == 0) ? 15 : int'($urandom_range(0, 15));
      v.exc      = (r == 0);
      v.eret     = (r == 1);
      v.redirect = (r >= 2 && r <= 5);
      v.npcSel   = 2'($urandom_range(0, 3));
      v.brOffset = 16'($urandom);
      v.jIndex   = 26'($urandom);
      v.jrTarget = $urandom;
      v.epc      = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      applyStimulus(v);

      preReq   = bus.imem_req;
      preAddr  = bus.imem_addr;
      preValid = bus.instr_valid;
      if (preValid && v.stall) checkBit("rnd_no_req_when_stalled", preReq, 1'b0);
      if (holdPending) begin
        checkBit("rnd_req_held", preReq, 1'b1);
        checkWord("rnd_addr_stable", preAddr, heldAddr);
      end
      holdPending = preReq && !v.ready;
      heldAddr    = preAddr;
      redir       = refRedir(v);
      tgt         = refTarget(v, modelInstrPc);

      @(posedge clk);
      #1;
      if (redir) begin
        checkBit("rnd_redirect_clears_valid", bus.instr_valid, 1'b0);
        expNext = tgt;
      end else if (bus.instr_valid && !(preValid && v.stall)) begin
        checkWord("rnd_instr_pc", bus.instr_pc, expNext);
        checkWord("rnd_instr_out", bus.instr_out, memWord(expNext));
        checkBit("rnd_capture_had_response", preReq && v.ready, 1'b1);
        modelInstrPc = expNext;
        expNext      = expNext + 32'd4;
        captures++;
      end else if (preValid && v.stall) begin
        checkBit("rnd_stall_holds_valid", bus.instr_valid, 1'b1);
        checkWord("rnd_stall_holds_pc", bus.instr_pc, modelInstrPc);
        checkWord("rnd_stall_holds_instr", bus.instr_out, memWord(modelInstrPc));
      end
    end
    checkBit("rnd_forward_progress", captures > 100, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
